batch_issuer: RTL and testbench

BATCH_ISSUER -- requirements
Module: batch_issuer

---
 rtl/batch_issuer.sv | 199 +++++++++++++++++++
 tb/tb_batch_issuer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/batch_issuer.sv
// batch_issuer: walks SBR -> SRR chain -> request chain and streams each
// request out on a valid/ready issue port.
// Every table read has 2-cycle latency. The address register holds its value
// until the data is sampled. A 3-bit valid shift register tracks the read.
// Optional feature: BATCH_ISSUER_COUNT_CHECK_EN builds a sticky err flag. The
// flag is set when the number of issued requests differs from the SBR total.
module batch_issuer #(
    parameter int SBR_ID_WIDTH     = 3,
    parameter int SRR_ID_WIDTH     = 3,
    parameter int REQUEST_ID_WIDTH = 4,
    parameter int BANK_GROUP_WIDTH = 2,
    parameter int BANK_WIDTH       = 2,
    parameter int ROW_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        done,
    output logic                        busy,
    input  logic [SBR_ID_WIDTH-1:0]     critical_sbr,
    output logic [SBR_ID_WIDTH-1:0]     sbr_rd_addr,
    input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_head_srr,
    input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_row_count,
    input  logic [REQUEST_ID_WIDTH-1:0] sbr_rd_total_requests,
    output logic [SRR_ID_WIDTH-1:0]     srr_rd_addr,
    input  logic [REQUEST_ID_WIDTH-1:0] srr_rd_head_req,
    input  logic [REQUEST_ID_WIDTH-1:0] srr_rd_count,
    input  logic [SRR_ID_WIDTH-1:0]     srr_rd_next,
    output logic [REQUEST_ID_WIDTH-1:0] req_rd_addr,
    input  logic [REQUEST_ID_WIDTH-1:0] req_rd_next,
    input  logic [BANK_GROUP_WIDTH-1:0] req_rd_bank_group,
    input  logic [BANK_WIDTH-1:0]       req_rd_bank,
    input  logic [ROW_WIDTH-1:0]        req_rd_row,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [REQUEST_ID_WIDTH-1:0] iss_req_id,
    output logic [BANK_GROUP_WIDTH-1:0] iss_bank_group,
    output logic [BANK_WIDTH-1:0]       iss_bank,
    output logic [ROW_WIDTH-1:0]        iss_row,
    output logic                        iss_row_first,
    output logic                        iss_last,
    output logic                        err
);

    typedef enum logic [2:0] {IDLE, RD_SBR, RD_SRR, RD_REQ, ISSUE, DONE} state_t;

    localparam logic [SRR_ID_WIDTH-1:0]     ROW_ONE = 1;
    localparam logic [REQUEST_ID_WIDTH-1:0] REQ_ONE = 1;

    state_t                      state, state_nxt;
    logic [2:0]                  rd_pipe;      // bit 2 = read data valid this cycle
    logic                        rd_hit;
    logic                        xfer;
    logic [SRR_ID_WIDTH-1:0]     rows_left, next_srr;
    logic [REQUEST_ID_WIDTH-1:0] reqs_left, next_req, issued_cnt;
    logic                        row_first;

    assign rd_hit   = rd_pipe[2];
    assign xfer     = iss_valid && iss_ready;
    // Counters are frozen during ISSUE, so this is exact for the whole beat
    assign iss_last = (state == ISSUE) && (reqs_left == REQ_ONE) && (rows_left == ROW_ONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = RD_SBR;
            RD_SBR: if (rd_hit) state_nxt = (sbr_rd_row_count == '0) ? DONE : RD_SRR;
            RD_SRR: if (rd_hit) begin
                        if (srr_rd_count != '0)      state_nxt = RD_REQ;
                        else if (rows_left == ROW_ONE) state_nxt = DONE;
                        else                           state_nxt = RD_SRR;
                    end
            RD_REQ: if (rd_hit) state_nxt = ISSUE;
            ISSUE:  if (xfer) begin
                        if (reqs_left > REQ_ONE)      state_nxt = RD_REQ;
                        else if (rows_left > ROW_ONE) state_nxt = RD_SRR;
                        else                          state_nxt = DONE;
                    end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Walk datapath: table addresses, counters, chain links, issue fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe        <= '0;
            sbr_rd_addr    <= '0;
            srr_rd_addr    <= '0;
            req_rd_addr    <= '0;
            rows_left      <= '0;
            reqs_left      <= '0;
            next_srr       <= '0;
            next_req       <= '0;
            issued_cnt     <= '0;
            row_first      <= 1'b0;
            iss_valid      <= 1'b0;
            iss_req_id     <= '0;
            iss_bank_group <= '0;
            iss_bank       <= '0;
            iss_row        <= '0;
            iss_row_first  <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            rd_pipe <= {rd_pipe[1:0], 1'b0};
            done    <= (state == DONE);
            busy    <= (state != IDLE);
            case (state)
                IDLE: if (start) begin
                    sbr_rd_addr <= critical_sbr;
                    rd_pipe     <= 3'b001;
                    rows_left   <= '0;
                    reqs_left   <= '0;
                    issued_cnt  <= '0;
                    row_first   <= 1'b0;
                end
                RD_SBR: if (rd_hit) begin
                    rows_left <= sbr_rd_row_count;
                    if (sbr_rd_row_count != '0) begin
                        srr_rd_addr <= sbr_rd_head_srr;
                        rd_pipe     <= 3'b001;
                    end
                end
                RD_SRR: if (rd_hit) begin
                    reqs_left <= srr_rd_count;
                    next_srr  <= srr_rd_next;
                    row_first <= 1'b1;
                    if (srr_rd_count != '0) begin
                        req_rd_addr <= srr_rd_head_req;
                        rd_pipe     <= 3'b001;
                    end else begin
                        // Empty SRR: consume the row and follow the link only if rows remain
                        rows_left <= rows_left - ROW_ONE;
                        if (rows_left != ROW_ONE) begin
                            srr_rd_addr <= srr_rd_next;
                            rd_pipe     <= 3'b001;
                        end
                    end
                end
                RD_REQ: if (rd_hit) begin
                    iss_valid      <= 1'b1;
                    iss_req_id     <= req_rd_addr;
                    iss_bank_group <= req_rd_bank_group;
                    iss_bank       <= req_rd_bank;
                    iss_row        <= req_rd_row;
                    iss_row_first  <= row_first;
                    next_req       <= req_rd_next;
                end
                ISSUE: if (xfer) begin
                    iss_valid     <= 1'b0;
                    iss_row_first <= 1'b0;
                    row_first     <= 1'b0;
                    reqs_left     <= reqs_left - REQ_ONE;
                    issued_cnt    <= issued_cnt + REQ_ONE;
                    if (reqs_left > REQ_ONE) begin
                        req_rd_addr <= next_req;
                        rd_pipe     <= 3'b001;
                    end else if (rows_left > ROW_ONE) begin
                        rows_left   <= rows_left - ROW_ONE;
                        srr_rd_addr <= next_srr;
                        rd_pipe     <= 3'b001;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BATCH_ISSUER_COUNT_CHECK_EN
    logic [REQUEST_ID_WIDTH-1:0] total;

    // Latch the expected request total when the SBR read returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        total <= '0;
        else if (state == IDLE && start) total <= '0;
        else if (state == RD_SBR && rd_hit) total <= sbr_rd_total_requests;
    end

    // Sticky mismatch flag, evaluated in the single DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (state == DONE && issued_cnt != total) err <= 1'b1;
    end
`else
    logic unused_total;
    assign unused_total = ^sbr_rd_total_requests;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_batch_issuer.sv
// Directed bench for batch_issuer with 2-cycle-latency table models.
module tb_batch_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done, busy;
    logic [2:0] critical_sbr, sbr_rd_addr, sbr_rd_head_srr, sbr_rd_row_count;
    logic [3:0] sbr_rd_total_requests;
    logic [2:0] srr_rd_addr, srr_rd_next;
    logic [3:0] srr_rd_head_req, srr_rd_count;
    logic [3:0] req_rd_addr, req_rd_next;
    logic [1:0] req_rd_bank_group, req_rd_bank;
    logic [7:0] req_rd_row;
    logic       iss_valid, iss_ready;
    logic [3:0] iss_req_id;
    logic [1:0] iss_bank_group, iss_bank;
    logic [7:0] iss_row;
    logic       iss_row_first, iss_last, err;

    always #5 clk = ~clk;

    batch_issuer dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .critical_sbr(critical_sbr), .sbr_rd_addr(sbr_rd_addr),
        .sbr_rd_head_srr(sbr_rd_head_srr), .sbr_rd_row_count(sbr_rd_row_count),
        .sbr_rd_total_requests(sbr_rd_total_requests),
        .srr_rd_addr(srr_rd_addr), .srr_rd_head_req(srr_rd_head_req),
        .srr_rd_count(srr_rd_count), .srr_rd_next(srr_rd_next),
        .req_rd_addr(req_rd_addr), .req_rd_next(req_rd_next),
        .req_rd_bank_group(req_rd_bank_group), .req_rd_bank(req_rd_bank),
        .req_rd_row(req_rd_row),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_req_id(iss_req_id),
        .iss_bank_group(iss_bank_group), .iss_bank(iss_bank), .iss_row(iss_row),
        .iss_row_first(iss_row_first), .iss_last(iss_last), .err(err)
    );

    // Table contents
    logic [2:0] sbr_head[8], sbr_rows[8];
    logic [3:0] sbr_total[8];
    logic [3:0] srr_head[8], srr_cnt[8];
    logic [2:0] srr_next[8];
    logic [3:0] req_next[16];

    // Two register stages between address and data
    logic [9:0]  sbr_p1, sbr_p2;
    logic [10:0] srr_p1, srr_p2;
    logic [15:0] req_p1, req_p2;
    always_ff @(posedge clk) begin
        sbr_p1 <= {sbr_head[sbr_rd_addr], sbr_rows[sbr_rd_addr], sbr_total[sbr_rd_addr]};
        sbr_p2 <= sbr_p1;
        srr_p1 <= {srr_head[srr_rd_addr], srr_cnt[srr_rd_addr], srr_next[srr_rd_addr]};
        srr_p2 <= srr_p1;
        req_p1 <= {req_next[req_rd_addr], req_rd_addr[1:0], req_rd_addr[3:2], req_rd_addr, 4'h3};
        req_p2 <= req_p1;
    end
    assign {sbr_rd_head_srr, sbr_rd_row_count, sbr_rd_total_requests} = sbr_p2;
    assign {srr_rd_head_req, srr_rd_count, srr_rd_next} = srr_p2;
    assign {req_rd_next, req_rd_bank_group, req_rd_bank, req_rd_row} = req_p2;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Per-walk capture
    int          got_n, n_valid;
    logic [63:0] got_ids;
    logic [15:0] got_first, got_last, got_stable, got_busy;
    logic [31:0] got_fields[16];
    logic        got_err, fin;

    // Starts at the current negedge (so it can chain straight off a done pulse)
    task automatic run_walk(input logic [2:0] sbr, input int stall);
        int          cnt;
        logic [17:0] cap;
        logic        stable;
        got_n = 0; n_valid = 0; got_ids = '0; got_first = '0; got_last = '0;
        got_stable = '0; got_busy = '0; got_err = 1'b0; fin = 1'b0;
        cnt = 0; stable = 1'b1; cap = '0;
        critical_sbr = sbr; start = 1'b1; iss_ready = (stall == 0);
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (iss_valid) begin
                n_valid++;
                if (cnt == 0) begin
                    cap = {iss_req_id, iss_bank_group, iss_bank, iss_row, iss_row_first, iss_last};
                    stable = 1'b1;
                end else if (cap !== {iss_req_id, iss_bank_group, iss_bank, iss_row, iss_row_first, iss_last})
                    stable = 1'b0;
                if (cnt < stall) begin
                    iss_ready = 1'b0; cnt++;
                end else begin
                    iss_ready = 1'b1; cnt = 0;
                    got_ids[got_n*4 +: 4] = iss_req_id;
                    got_first[got_n]      = iss_row_first;
                    got_last[got_n]       = iss_last;
                    got_stable[got_n]     = stable;
                    got_busy[got_n]       = busy;
                    got_fields[got_n]     = {18'd0, iss_bank_group, iss_bank, iss_row, iss_req_id};
                    got_n++;
                end
            end else iss_ready = (stall == 0);
            if (done) begin
                got_err = err; fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("walk_finished", {31'd0, fin}, 32'd1);
    endtask

    logic exp_err;
    logic [31:0] outs;
    assign outs = {iss_valid, iss_req_id, iss_bank_group, iss_bank, iss_row, iss_row_first,
                   iss_last, done, busy, err, sbr_rd_addr, srr_rd_addr, req_rd_addr};

    initial begin
`ifdef BATCH_ISSUER_COUNT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            sbr_head[i] = '0; sbr_rows[i] = '0; sbr_total[i] = '0;
            srr_head[i] = '0; srr_cnt[i] = '0; srr_next[i] = '0;
        end
        for (int i = 0; i < 16; i++) req_next[i] = '0;
        // SBR2: one row, 5->9->3
        sbr_head[2] = 3'd0; sbr_rows[2] = 3'd1; sbr_total[2] = 4'd3;
        srr_head[0] = 4'd5; srr_cnt[0] = 4'd3; srr_next[0] = 3'd7;
        req_next[5] = 4'd9; req_next[9] = 4'd3; req_next[3] = 4'd15;
        // SBR3: two rows, 1->2 then 4->6
        sbr_head[3] = 3'd1; sbr_rows[3] = 3'd2; sbr_total[3] = 4'd4;
        srr_head[1] = 4'd1; srr_cnt[1] = 4'd2; srr_next[1] = 3'd2;
        srr_head[2] = 4'd4; srr_cnt[2] = 4'd2; srr_next[2] = 3'd7;
        req_next[1] = 4'd2; req_next[2] = 4'd13; req_next[4] = 4'd6; req_next[6] = 4'd14;
        // SBR4: no rows
        sbr_head[4] = 3'd3; sbr_rows[4] = 3'd0; sbr_total[4] = 4'd0;
        // SBR5: rows 7 / empty / 8
        sbr_head[5] = 3'd3; sbr_rows[5] = 3'd3; sbr_total[5] = 4'd2;
        srr_head[3] = 4'd7;  srr_cnt[3] = 4'd1; srr_next[3] = 3'd4;
        srr_head[4] = 4'd15; srr_cnt[4] = 4'd0; srr_next[4] = 3'd5;
        srr_head[5] = 4'd8;  srr_cnt[5] = 4'd1; srr_next[5] = 3'd6;
        // SBR6: total says 4, chain holds 10->11->12
        sbr_head[6] = 3'd6; sbr_rows[6] = 3'd1; sbr_total[6] = 4'd4;
        srr_head[6] = 4'd10; srr_cnt[6] = 4'd3; srr_next[6] = 3'd0;
        req_next[10] = 4'd11; req_next[11] = 4'd12; req_next[12] = 4'd0;

        rst = 1'b1; start = 1'b0; iss_ready = 1'b0; critical_sbr = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single row, no backpressure
        run_walk(3'd2, 0);
        chk("a_count", got_n, 3);
        chk("a_ids", {20'd0, got_ids[11:0]}, 32'h395);
        chk("a_first", {29'd0, got_first[2:0]}, 32'b001);
        chk("a_last", {29'd0, got_last[2:0]}, 32'b100);
        chk("a_fields_id9", got_fields[1], {18'd0, 2'd1, 2'd2, 8'd147, 4'd9});
        chk("a_busy", {31'd0, got_busy[0]}, 32'd1);
        chk("a_err", {31'd0, got_err}, 32'd0);

        // Back-to-back start, two rows with 3-cycle stalls
        run_walk(3'd3, 3);
        chk("b_count", got_n, 4);
        chk("b_ids", {16'd0, got_ids[15:0]}, 32'h6421);
        chk("b_first", {28'd0, got_first[3:0]}, 32'b0101);
        chk("b_last", {28'd0, got_last[3:0]}, 32'b1000);
        chk("b_stable", {28'd0, got_stable[3:0]}, 32'b1111);
        chk("b_valid_cycles", n_valid, 16);

        // Empty SBR
        run_walk(3'd4, 0);
        chk("c_valid_cycles", n_valid, 0);
        @(negedge clk);
        chk("c_done_one_pulse", {31'd0, done}, 32'd0);

        // Empty middle SRR is skipped
        run_walk(3'd5, 0);
        chk("d_count", got_n, 2);
        chk("d_ids", {24'd0, got_ids[7:0]}, 32'h87);
        chk("d_first", {30'd0, got_first[1:0]}, 32'b11);
        chk("d_last", {30'd0, got_last[1:0]}, 32'b10);

        // Count mismatch
        run_walk(3'd6, 0);
        chk("e_ids", {20'd0, got_ids[11:0]}, 32'hCBA);
        chk("e_err", {31'd0, got_err}, {31'd0, exp_err});
        @(negedge clk);
        chk("e_err_sticky", {31'd0, err}, {31'd0, exp_err});

        // Next start clears err
        run_walk(3'd2, 0);
        chk("f_err_cleared", {31'd0, got_err}, 32'd0);

        // Reset mid-ISSUE with iss_valid held
        critical_sbr = 3'd2; start = 1'b1; iss_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50 && !iss_valid; c++) @(negedge clk);
        chk("g_reached_issue", {31'd0, iss_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("g_async_clear", outs, 32'd0);
        @(negedge clk);
        chk("g_reset_hold", outs, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_walk(3'd2, 0);
        chk("g_after_reset_ids", {20'd0, got_ids[11:0]}, 32'h395);
        chk("g_after_reset_last", {29'd0, got_last[2:0]}, 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
